// File: rtl/adder4b_scb_pkg.sv
// rtl/adder4b_scb_pkg.sv - shared types, default sizes and sum-width helper for adder4b_scoreboard
package adder4b_scb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HALT   = 2'd2
  } scb_state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_CNT_W = 8;

  function automatic int sum_width(input int w);
    return w + 1;
  endfunction

endpackage

// File: rtl/scb_sync_fifo.sv
// rtl/scb_sync_fifo.sv - synchronous FIFO with exact level; a push on full is taken when a pop frees the slot
module scb_sync_fifo #(
  parameter int DW    = 5,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            wdata,
  output logic [DW-1:0]            rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  // Head is read combinationally, so a same-edge write to the same slot is never seen by this pop
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      level <= level + LW'(push_ok) - LW'(pop_ok);
    end
  end

endmodule

// File: rtl/adder4b_scoreboard.sv
// rtl/adder4b_scoreboard.sv - expected-sum scoreboard for the 4-bit adder: queue, compare, counters, FSM
// Optional SCB_STOP_ON_ERR_EN: first mismatch/underflow freezes the checker in HALT until reset.
module adder4b_scoreboard
  import adder4b_scb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [WIDTH-1:0]            A,
  input  logic [WIDTH-1:0]            B,
  input  logic                        dut_valid,
  input  logic [sum_width(WIDTH)-1:0] dut_sum,
  output logic                        mismatch,
  output logic                        underflow,
  output logic                        overflow,
  output logic [CNT_W-1:0]            match_cnt,
  output logic [CNT_W-1:0]            err_cnt,
  output logic [$clog2(DEPTH):0]      level,
  output logic [1:0]                  state
);

  localparam int SW = sum_width(WIDTH);
  localparam int LW = $clog2(DEPTH) + 1;

  scb_state_t    state_q;
  scb_state_t    state_d;
  logic [SW-1:0] sum_in;
  logic [SW-1:0] head;
  logic          full;
  logic          empty;
  logic          push_req;
  logic          pop_req;
  logic          push_acc;
  logic          pop_acc;
  logic          is_match;
  logic          is_mis;
  logic          is_under;
  logic          is_over;
  logic          err_evt;
  logic [LW-1:0]    level_d;
  logic [CNT_W-1:0] err_d;
  logic [CNT_W-1:0] match_d;

  // HALT masks both strobes, which freezes the queue, counters and pulses together
  assign push_req = enable && (state_q != HALT);
  assign pop_req  = dut_valid && (state_q != HALT);
  assign sum_in   = SW'(A) + SW'(B);

  scb_sync_fifo #(
    .DW    (SW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop_req),
    .wdata (sum_in),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign pop_acc  = pop_req && !empty;
  assign push_acc = push_req && (!full || pop_acc);
  assign is_match = pop_acc && (head == dut_sum);
  assign is_mis   = pop_acc && (head != dut_sum);
  assign is_under = pop_req && empty;
  assign is_over  = push_req && full && !pop_req;
  assign err_evt  = is_mis || is_under;

  assign level_d = level + LW'(push_acc) - LW'(pop_acc);
  assign err_d   = (err_evt && (err_cnt != '1)) ? err_cnt + CNT_W'(1) : err_cnt;
  assign match_d = (is_match && (match_cnt != '1)) ? match_cnt + CNT_W'(1) : match_cnt;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (push_acc) state_d = ACTIVE;
      ACTIVE:  if (!push_acc && (level_d == '0) && (err_d == '0)) state_d = IDLE;
      default: state_d = state_q;
    endcase
`ifdef SCB_STOP_ON_ERR_EN
    if ((state_q != HALT) && err_evt) state_d = HALT;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      mismatch  <= 1'b0;
      underflow <= 1'b0;
      overflow  <= 1'b0;
      match_cnt <= '0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      mismatch  <= is_mis;
      underflow <= is_under;
      overflow  <= is_over;
      match_cnt <= match_d;
      err_cnt   <= err_d;
    end
  end

  assign state = state_q;

endmodule
